spi_responder: RTL

SPI_RESPONDER -- requirements
Module: spi_responder

---
 rtl/spi_responder.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_responder.sv
// spi_responder: SPI mode-0 responder that turns serial frames into
// register-bus accesses. The first byte of a frame is a command
// (bit 7 = write, bits 6:0 = start address). Each following byte is
// either write data or a dummy byte clocked out against prefetched read
// data. The address auto-increments and wraps at 7'h7F.
// Everything runs on clk_i. SPI pins are oversampled through synchronizers.
module spi_responder #(
  parameter int SyncStages = 2,
  parameter int DataWidth  = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 spi_clk_i,
  input  logic                 spi_cs_n_i,
  input  logic                 spi_mosi_i,
  output logic                 spi_miso_o,
  output logic [6:0]           reg_addr_o,
  output logic [DataWidth-1:0] reg_wdata_o,
  output logic                 reg_we_o,
  output logic                 reg_re_o,
  input  logic [DataWidth-1:0] reg_rdata_i,
  output logic                 busy_o
);

  localparam int              CntW    = (DataWidth > 1) ? $clog2(DataWidth) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DataWidth - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  // Synchronizer chains and edge history
  logic [SyncStages-1:0] sclk_sync_q, sclk_sync_d;
  logic [SyncStages-1:0] cs_sync_q, cs_sync_d;
  logic [SyncStages-1:0] mosi_sync_q, mosi_sync_d;
  logic                  sclk_prev_q, sclk_prev_d;
  logic                  cs_prev_q, cs_prev_d;
  // primed/armed: ignore the CS "fall" produced when the preset-high chain
  // first fills with a low CS that was already low during reset
  logic                  primed_q, primed_d;
  logic                  armed_q, armed_d;

  // Protocol state
  state_e                state_q, state_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DataWidth-1:0]  shift_q, shift_d;
  logic                  is_write_q, is_write_d;
  logic [6:0]            addr_q, addr_d;
  logic [DataWidth-1:0]  wdata_q, wdata_d;
  logic                  we_pend_q, we_pend_d;
  logic                  we_q, we_d;
  logic                  re_q, re_d;
  logic                  capture_q, capture_d;
  logic [DataWidth-1:0]  tx_buf_q, tx_buf_d;
  logic                  load_pend_q, load_pend_d;
  logic [DataWidth-1:0]  miso_sh_q, miso_sh_d;
  logic                  busy_q, busy_d;

  // Combinational helpers
  logic                  sclk_s, cs_s, mosi_s;
  logic                  sclk_rise_s, sclk_fall_s, cs_fall_s;
  logic [DataWidth-1:0]  shift_next_s;
  logic                  byte_done_s;

  // Synchronize SPI pins, detect SCLK/CS edges, and arm after reset
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SyncStages-2:0], spi_clk_i};
    cs_sync_d   = {cs_sync_q[SyncStages-2:0], spi_cs_n_i};
    mosi_sync_d = {mosi_sync_q[SyncStages-2:0], spi_mosi_i};
    sclk_s      = sclk_sync_q[SyncStages-1];
    cs_s        = cs_sync_q[SyncStages-1];
    mosi_s      = mosi_sync_q[SyncStages-1];
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    sclk_rise_s = sclk_s & ~sclk_prev_q;
    sclk_fall_s = ~sclk_s & sclk_prev_q;
    cs_fall_s   = ~cs_s & cs_prev_q;
    primed_d    = 1'b1;
    armed_d     = armed_q | (primed_q & cs_sync_q[0]);
  end

  // Next-state logic: frame decoding, strobe pipeline, and MISO shifting
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    is_write_d   = is_write_q;
    wdata_d      = wdata_q;
    tx_buf_d     = tx_buf_q;
    load_pend_d  = load_pend_q;
    miso_sh_d    = miso_sh_q;
    shift_next_s = {shift_q[DataWidth-2:0], mosi_s};
    byte_done_s  = (bit_cnt_q == LastBit);

    // Strobe pipeline keeps running after CS rises, so a completed byte
    // still gets its strobe
    we_pend_d = 1'b0;
    we_d      = we_pend_q;
    re_d      = 1'b0;
    capture_d = re_q;

    if (we_q || capture_q) begin
      addr_d = addr_q + 7'd1;
    end else begin
      addr_d = addr_q;
    end

    if (capture_q) begin
      tx_buf_d = reg_rdata_i;
    end else begin
      tx_buf_d = tx_buf_q;
    end

    case (state_q)
      ST_IDLE: begin
        miso_sh_d   = '0;
        load_pend_d = 1'b0;
        if (cs_fall_s && armed_q) begin
          state_d   = ST_CMD;
          bit_cnt_d = '0;
        end else begin
          state_d   = ST_IDLE;
        end
      end

      ST_CMD: begin
        miso_sh_d = '0;
        if (cs_s) begin
          state_d = ST_IDLE;
        end else if (sclk_rise_s) begin
          shift_d = shift_next_s;
          if (byte_done_s) begin
            bit_cnt_d   = '0;
            state_d     = ST_DATA;
            is_write_d  = shift_next_s[DataWidth-1];
            addr_d      = shift_next_s[DataWidth-2 -: 7];
            re_d        = ~shift_next_s[DataWidth-1];
            load_pend_d = ~shift_next_s[DataWidth-1];
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end else begin
          state_d = ST_CMD;
        end
      end

      ST_DATA: begin
        if (cs_s) begin
          // Partial byte is simply dropped; no strobe is raised for it
          state_d = ST_IDLE;
        end else if (sclk_rise_s) begin
          shift_d = shift_next_s;
          if (byte_done_s) begin
            bit_cnt_d = '0;
            if (is_write_q) begin
              wdata_d   = shift_next_s;
              we_pend_d = 1'b1;
            end else begin
              re_d        = 1'b1;
              load_pend_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end else if (sclk_fall_s) begin
          if (is_write_q) begin
            miso_sh_d = '0;
          end else if (load_pend_q) begin
            miso_sh_d   = tx_buf_q;
            load_pend_d = 1'b0;
          end else begin
            miso_sh_d = {miso_sh_q[DataWidth-2:0], 1'b0};
          end
        end else begin
          state_d = ST_DATA;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        miso_sh_d = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and data registers; reset aborts everything in flight
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      primed_q    <= 1'b0;
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      is_write_q  <= 1'b0;
      addr_q      <= 7'd0;
      wdata_q     <= '0;
      we_pend_q   <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      capture_q   <= 1'b0;
      tx_buf_q    <= '0;
      load_pend_q <= 1'b0;
      miso_sh_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      primed_q    <= primed_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      is_write_q  <= is_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_pend_q   <= we_pend_d;
      we_q        <= we_d;
      re_q        <= re_d;
      capture_q   <= capture_d;
      tx_buf_q    <= tx_buf_d;
      load_pend_q <= load_pend_d;
      miso_sh_q   <= miso_sh_d;
      busy_q      <= busy_d;
    end
  end

  assign spi_miso_o  = miso_sh_q[DataWidth-1];
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_we_o    = we_q;
  assign reg_re_o    = re_q;
  assign busy_o      = busy_q;

endmodule
